// File: rtl/mem_access_ctrl.sv
// CPU data-memory access sequencer: single-phase word loads/stores and read-modify-write
// byte/halfword stores onto a word bus with waitrequest handshake and timeout abort.
module mem_access_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        err,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]         op_q, op_d;
  logic [31:0]        addr_q, addr_d;
  logic [15:0]        wdata_q, wdata_d;
  logic [31:0]        rbuf_q, rbuf_d;
  logic [31:0]        wbuf_q, wbuf_d;
  logic               err_q, err_d;

  function automatic logic is_load(input logic [5:0] o);
    return (o == OP_LB) || (o == OP_LH) || (o == OP_LWL) || (o == OP_LW) ||
           (o == OP_LBU) || (o == OP_LHU) || (o == OP_LWR);
  endfunction

  function automatic logic op_valid(input logic [5:0] o);
    return is_load(o) || (o == OP_SB) || (o == OP_SH) || (o == OP_SW);
  endfunction

  function automatic logic misaligned(input logic [5:0] o, input logic [1:0] a);
    if ((o == OP_LW) || (o == OP_SW)) return a != 2'b00;
    if ((o == OP_LH) || (o == OP_LHU) || (o == OP_SH)) return a[0];
    return 1'b0;
  endfunction

  // Overlay the store lanes selected by the byte address onto the word just read.
  function automatic logic [31:0] merge_lanes(input logic [31:0] word, input logic [5:0] o,
                                              input logic [1:0] a, input logic [15:0] wd);
    logic [31:0] r;
    r = word;
    if (o == OP_SB) r[8*a +: 8] = wd[7:0];
    else            r[16*a[1] +: 16] = wd;
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      wbuf_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
      wbuf_q  <= wbuf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    wbuf_d      = wbuf_q;
    err_d       = err_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    rdata_valid = 1'b0;
    err         = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (req && op_valid(op)) begin
          op_d    = op;
          addr_d  = addr;
          wdata_d = wdata[15:0];
          err_d   = 1'b0;
          if (misaligned(op, addr[1:0])) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (op == OP_SW) begin
            wbuf_d  = wdata;
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        mem_read = 1'b1;
        if (mem_waitrequest) begin
          if (cnt_q == WAIT_W'(MAX_WAIT - 1)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          rbuf_d = mem_readdata;
          cnt_d  = '0;
          if ((op_q == OP_SB) || (op_q == OP_SH)) begin
            wbuf_d  = merge_lanes(mem_readdata, op_q, addr_q[1:0], wdata_q);
            state_d = S_WRITE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WRITE: begin
        mem_write = 1'b1;
        if (mem_waitrequest) begin
          if (cnt_q == WAIT_W'(MAX_WAIT - 1)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        rdata_valid = is_load(op_q) && !err_q;
        err         = err_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stall         = req && op_valid(op) && (state_q != S_DONE);
  assign rdata         = rbuf_q;
  assign mem_address   = {addr_q[31:2], 2'b00};
  assign mem_writedata = wbuf_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a waitrequest memory responder plus a transaction-level
// reference that predicts stall length, pulses, bus traffic and final memory contents.
module tb_mem_access_ctrl;

  localparam int MAXW = 8;

  localparam logic [5:0] OP_LB  = 6'h20, OP_LH  = 6'h21, OP_LWL = 6'h22, OP_LW = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24, OP_LHU = 6'h25, OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28, OP_SH  = 6'h29, OP_SW  = 6'h2B;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [5:0]  op;
  logic [31:0] addr, wdata;
  logic        stall, rdata_valid, err;
  logic [31:0] rdata, mem_address, mem_writedata, mem_readdata;
  logic        mem_read, mem_write, mem_waitrequest;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem_m [bit [29:0]];
  int          rd_waits, wr_waits, wcnt, n_rd, n_wr;
  logic [31:0] exp_addr, held_addr, held_wd;

  mem_access_ctrl #(.MAX_WAIT(MAXW), .WAIT_W(4)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .err(err),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_waitrequest(mem_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Memory responder: inserts the planned number of wait cycles per bus phase.
  always @(negedge clk) begin
    if (reset) begin
      mem_waitrequest = 1'b0;
      wcnt = 0;
    end else if (mem_read || mem_write) begin
      check("excl_strobes", {31'b0, mem_read & mem_write}, 32'd0);
      check("bus_addr", mem_address, exp_addr);
      if (wcnt > 0) begin
        check("addr_stable", mem_address, held_addr);
        if (mem_write) check("wdata_stable", mem_writedata, held_wd);
      end
      held_addr = mem_address;
      held_wd   = mem_writedata;
      if (wcnt < (mem_read ? rd_waits : wr_waits)) begin
        mem_waitrequest = 1'b1;
        wcnt++;
      end else begin
        mem_waitrequest = 1'b0;
        wcnt = 0;
        if (mem_read) begin
          mem_readdata = mem_m[mem_address[31:2]];
          n_rd++;
        end else begin
          mem_m[mem_address[31:2]] = mem_writedata;
          n_wr++;
        end
      end
    end else begin
      mem_waitrequest = 1'b0;
      wcnt = 0;
    end
  end

  function automatic logic is_load(input logic [5:0] o);
    return o inside {OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR};
  endfunction

  // Issue one access, then compare everything observed against the reference prediction.
  task automatic do_access(input logic [5:0] o, input logic [31:0] a, input logic [31:0] wd,
                           input int rw, input int ww);
    bit [29:0]   idx;
    logic [31:0] old_w, new_w, mask;
    bit          valid, mis, needs_rd, needs_wr, rd_ok, wr_ok, e_err;
    int          e_stall, e_nrd, e_nwr, sc;
    idx = a[31:2];
    if (!mem_m.exists(idx)) mem_m[idx] = $urandom;
    old_w    = mem_m[idx];
    valid    = is_load(o) || o inside {OP_SB, OP_SH, OP_SW};
    mis      = ((o == OP_LW || o == OP_SW) && a[1:0] != 2'b00) ||
               ((o == OP_LH || o == OP_LHU || o == OP_SH) && a[0]);
    needs_rd = valid && !mis && o != OP_SW;
    rd_ok    = needs_rd && rw < MAXW;
    needs_wr = valid && !mis && (o == OP_SW || ((o == OP_SB || o == OP_SH) && rd_ok));
    wr_ok    = needs_wr && ww < MAXW;
    e_nrd    = rd_ok ? 1 : 0;
    e_nwr    = wr_ok ? 1 : 0;
    e_err    = valid && (mis || (needs_rd && !rd_ok) || (needs_wr && !wr_ok));
    e_stall  = 0;
    if (valid) begin
      e_stall = 1;
      if (needs_rd) e_stall += (rw < MAXW) ? rw + 1 : MAXW;
      if (needs_wr) e_stall += (ww < MAXW) ? ww + 1 : MAXW;
    end
    new_w = old_w;
    if (wr_ok) begin
      if (o == OP_SW) new_w = wd;
      else if (o == OP_SB) begin
        mask  = 32'hFF << (8 * a[1:0]);
        new_w = (old_w & ~mask) | ((wd & 32'hFF) << (8 * a[1:0]));
      end else begin
        mask  = 32'hFFFF << (16 * a[1]);
        new_w = (old_w & ~mask) | ((wd & 32'hFFFF) << (16 * a[1]));
      end
    end

    rd_waits = rw;
    wr_waits = ww;
    exp_addr = {a[31:2], 2'b00};
    n_rd = 0;
    n_wr = 0;
    req = 1'b1; op = o; addr = a; wdata = wd;
    sc = 0;
    #1;
    while (stall === 1'b1 && sc < 100) begin
      sc++;
      @(negedge clk);
      #1;
    end
    if (sc >= 100) check("stall_timeout", 32'd1, 32'd0);
    check("stall_cycles", sc, e_stall);
    check("err", {31'b0, err}, {31'b0, e_err});
    check("rdata_valid", {31'b0, rdata_valid}, {31'b0, valid && is_load(o) && !e_err});
    if (valid && is_load(o) && !e_err) check("rdata", rdata, old_w);
    check("done_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    check("n_reads", n_rd, e_nrd);
    check("n_writes", n_wr, e_nwr);
    check("mem_word", mem_m[idx], new_w);
    @(negedge clk);
    req = 1'b0;
  endtask

  logic [5:0] op_tab [12];
  int         k;

  initial begin
    op_tab = '{OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
               OP_SB, OP_SH, OP_SW, 6'h00, 6'h2A};
    reset = 1'b1; req = 1'b0; op = '0; addr = '0; wdata = '0;
    mem_readdata = '0; mem_waitrequest = 1'b0;
    rd_waits = 0; wr_waits = 0; wcnt = 0; n_rd = 0; n_wr = 0;
    exp_addr = '0; held_addr = '0; held_wd = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    check("rst_pulses", {30'b0, err, rdata_valid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_addr", mem_address, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    mem_m[30'h1004 >> 2] = 32'hDEADBEEF;
    do_access(OP_LW, 32'h1004, 32'h0, 0, 0);
    mem_m[30'h2000 >> 2] = 32'h11223344;
    do_access(OP_SB, 32'h2003, 32'hAB, 0, 0);
    check("sb_word", mem_m[30'h2000 >> 2], 32'hAB223344);
    mem_m[30'h2000 >> 2] = 32'h11223344;
    do_access(OP_SH, 32'h2002, 32'hCAFE, 3, 0);
    check("sh_word", mem_m[30'h2000 >> 2], 32'hCAFE3344);
    do_access(OP_SW, 32'h3001, 32'h12345678, 0, 0);
    do_access(OP_LH, 32'h3003, 32'h0, 0, 0);
    do_access(OP_SW, 32'h3000, 32'h55AA55AA, 0, 20);
    do_access(OP_SB, 32'h3005, 32'h77, 0, 20);
    do_access(OP_LBU, 32'h3006, 32'h0, 20, 0);
    do_access(OP_LWR, 32'h3007, 32'h0, MAXW - 1, 0);
    do_access(OP_SH, 32'h3008, 32'h1357, MAXW - 1, MAXW - 1);
    do_access(6'h0F, 32'h3000, 32'h0, 0, 0);

    // Reset in the middle of a stalled write must drop the strobe at once.
    mem_m[30'h4000 >> 2] = 32'h0BADF00D;
    exp_addr = 32'h4000; wr_waits = 20; n_wr = 0;
    req = 1'b1; op = OP_SW; addr = 32'h4000; wdata = 32'hFFFFFFFF;
    k = 0;
    while (!mem_write && k < 5) begin
      @(negedge clk);
      k++;
    end
    check("saw_write", {31'b0, mem_write}, 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_write_drop", {30'b0, mem_read, mem_write}, 32'd0);
    req = 1'b0;
    check("rst_mem_kept", mem_m[30'h4000 >> 2], 32'h0BADF00D);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mem_m[0] = 32'h00C0FFEE;
    do_access(OP_LW, 32'h0, 32'h0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      int rw, ww;
      rw = ($urandom_range(0, 9) == 0) ? $urandom_range(MAXW - 1, MAXW + 2) : $urandom_range(0, 3);
      ww = ($urandom_range(0, 9) == 0) ? $urandom_range(MAXW - 1, MAXW + 2) : $urandom_range(0, 3);
      do_access(op_tab[$urandom_range(0, 11)], 32'h100 + $urandom_range(0, 63), $urandom, rw, ww);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
